// File: rtl/uart_receiver_ctrl_pkg.sv
// Shared types and helpers for the UART receive path: FSM states,
// word-length codes, latched frame configuration and status flags.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LAST_SHIFT,
    CAPTURE
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
  } rx_cfg_t;

  typedef struct packed {
    logic parity_err;
    logic framing_err;
    logic break_det;
    logic overrun_err;
  } rx_flags_t;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (3'd3 - {1'b0, wls});
  endfunction

endpackage

// File: rtl/uart_receiver_ctrl_if.sv
// Receiver controller link to the shift block and the RBR/LSR register logic.
interface uart_receiver_ctrl_if;
  logic       rbr_full;
  logic [7:0] rsr_data;
  logic       receive_shift_en;
  logic       error_check;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       framing_err;
  logic       break_det;
  logic       overrun_err;
  logic       rx_busy;

  modport master (
    input  rbr_full, rsr_data,
    output receive_shift_en, error_check, rx_done, rx_data,
           parity_err, framing_err, break_det, overrun_err, rx_busy
  );

  modport slave (
    output rbr_full, rsr_data,
    input  receive_shift_en, error_check, rx_done, rx_data,
           parity_err, framing_err, break_det, overrun_err, rx_busy
  );
endinterface

// File: rtl/uart_receiver_ctrl_sync_edge.sv
// Multi-flop synchroniser for an idle-high serial line with a 1->0 edge flag.
module uart_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic din_i,
  output logic sync_o,
  output logic fall_o
);

  // One extra flop beyond the synchroniser holds the previous synchronised value.
  logic [SYNC_STAGES:0] sync_q;

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], din_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = sync_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver_ctrl.sv
// UART receive sequencer: start-bit hunt, mid-bit shift strobes, frame
// capture and LSR status generation on a 16x oversampling tick.
module uart_receiver_ctrl
  import uart_pkg::*;
#(
  parameter int OS_RATE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 baud_tick,
  input  logic                 uart_rxd,
  input  logic                 loop_txd,
  input  logic                 loop,
  input  logic [1:0]           wls,
  input  logic                 pen,
  input  logic                 eps,
  input  logic                 sp,
  uart_receiver_ctrl_if.master rx_if
);

  localparam int TICK_W = $clog2(OS_RATE);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OS_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);

  logic rxd;
  logic rxd_fall;

  uart_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .din_i   (loop ? loop_txd : uart_rxd),
    .sync_o  (rxd),
    .fall_o  (rxd_fall)
  );

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  rx_cfg_t           cfg_q, cfg_d;
  logic              par_acc_q, par_acc_d;
  logic              any_one_q, any_one_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_bit_q, stop_bit_d;
  logic              shift_en_q, shift_en_d;
  logic              rx_done_q, rx_done_d;
  logic [7:0]        rx_data_q, rx_data_d;
  rx_flags_t         flags_q, flags_d;
  logic              mid_bit;
  logic              exp_par;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    cfg_d      = cfg_q;
    par_acc_d  = par_acc_q;
    any_one_d  = any_one_q;
    par_bit_d  = par_bit_q;
    stop_bit_d = stop_bit_q;
    shift_en_d = 1'b0;
    rx_done_d  = 1'b0;
    rx_data_d  = rx_data_q;
    flags_d    = flags_q;
    mid_bit    = baud_tick && (tick_cnt_q == TICK_LAST);
    exp_par    = cfg_q.sp ? ~cfg_q.eps : (cfg_q.eps ? par_acc_q : ~par_acc_q);

    // Counter wraps to 0 by itself at the mid-bit sample point.
    if (baud_tick && (state_q inside {START, DATA, PARITY, STOP})) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rxd_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          cfg_d      = '{wls: wls, pen: pen, eps: eps, sp: sp};
        end
      end
      START: begin
        if (baud_tick && (tick_cnt_q == TICK_HALF)) begin
          tick_cnt_d = '0;
          if (!rxd) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            any_one_d = 1'b0;
            par_bit_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_en_d = 1'b1;
          par_acc_d  = par_acc_q ^ rxd;
          any_one_d  = any_one_q | rxd;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if ({1'b0, bit_cnt_q} == data_bits(cfg_q.wls) - 4'd1) begin
            state_d = cfg_q.pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (mid_bit) begin
          shift_en_d = 1'b1;
          par_bit_d  = rxd;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          shift_en_d = 1'b1;
          stop_bit_d = rxd;
          state_d    = LAST_SHIFT;
        end
      end
      LAST_SHIFT: state_d = CAPTURE;
      CAPTURE: begin
        rx_done_d           = 1'b1;
        rx_data_d           = rx_if.rsr_data & data_mask(cfg_q.wls);
        flags_d.parity_err  = cfg_q.pen & (par_bit_q != exp_par);
        flags_d.framing_err = ~stop_bit_q;
        flags_d.break_det   = ~any_one_q & ~(cfg_q.pen & par_bit_q) & ~stop_bit_q;
        flags_d.overrun_err = rx_if.rbr_full;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      cfg_q      <= '0;
      par_acc_q  <= 1'b0;
      any_one_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_bit_q <= 1'b0;
      shift_en_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cfg_q      <= cfg_d;
      par_acc_q  <= par_acc_d;
      any_one_q  <= any_one_d;
      par_bit_q  <= par_bit_d;
      stop_bit_q <= stop_bit_d;
      shift_en_q <= shift_en_d;
      rx_done_q  <= rx_done_d;
      rx_data_q  <= rx_data_d;
      flags_q    <= flags_d;
    end
  end

  assign rx_if.receive_shift_en = shift_en_q;
  assign rx_if.error_check      = (state_q == CAPTURE);
  assign rx_if.rx_done          = rx_done_q;
  assign rx_if.rx_data          = rx_data_q;
  assign rx_if.parity_err       = flags_q.parity_err;
  assign rx_if.framing_err      = flags_q.framing_err;
  assign rx_if.break_det        = flags_q.break_det;
  assign rx_if.overrun_err      = flags_q.overrun_err;
  assign rx_if.rx_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_ctrl.sv
// Directed plus randomized frame bench for uart_receiver_ctrl; expectations
// come from a frame-level model of the UART line protocol.
module tb_uart_receiver_ctrl;

  localparam int BIT_CLKS = 64;

  logic       pclk      = 1'b0;
  logic       presetn   = 1'b1;
  logic       baud_tick = 1'b0;
  logic       uart_rxd  = 1'b1;
  logic       loop_txd  = 1'b1;
  logic       loop      = 1'b0;
  logic [1:0] wls       = 2'b00;
  logic       pen       = 1'b0;
  logic       eps       = 1'b0;
  logic       sp        = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int baud_div = 0;
  int shift_cnt = 0, done_cnt = 0, ec_cnt = 0, busy_cnt = 0;
  int last_shift_cyc = 0, done_cyc = 0, ec_cyc = 0;

  uart_receiver_ctrl_if rx_if();

  uart_receiver_ctrl #(.OS_RATE(16), .SYNC_STAGES(2)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .baud_tick (baud_tick),
    .uart_rxd  (uart_rxd),
    .loop_txd  (loop_txd),
    .loop      (loop),
    .wls       (wls),
    .pen       (pen),
    .eps       (eps),
    .sp        (sp),
    .rx_if     (rx_if)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    baud_div  = (baud_div + 1) % 4;
    baud_tick = (baud_div == 0);
  end

  // Event monitor: counts strobes and remembers when they happened.
  always @(negedge pclk) begin
    if (rx_if.receive_shift_en === 1'b1) begin
      shift_cnt++;
      last_shift_cyc = cyc;
    end
    if (rx_if.rx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_if.error_check === 1'b1) begin
      ec_cnt++;
      ec_cyc = cyc;
    end
    if (rx_if.rx_busy === 1'b1) busy_cnt++;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic b);
    if (loop) loop_txd = b;
    else uart_rxd = b;
  endtask

  task automatic drive_bit(input logic b);
    set_line(b);
    repeat (BIT_CLKS) @(negedge pclk);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] w, input logic p, input logic e,
                           input logic s, input logic [7:0] d, input logic pbit,
                           input logic sbit, input logic rbr, input int gap);
    int nb, sh0, dn0, ec0, ones;
    logic [7:0] m, exp_d;
    logic exp_par, exp_pe, exp_fe, exp_bk;
    nb  = 5 + int'(w);
    m   = 8'hFF >> (3 - int'(w));
    sh0 = shift_cnt;
    dn0 = done_cnt;
    ec0 = ec_cnt;
    wls = w; pen = p; eps = e; sp = s;
    rx_if.rbr_full = rbr;
    rx_if.rsr_data = (d & m) | (8'($urandom) & ~m);
    drive_bit(1'b0);
    // Configuration changes after the start bit must not affect this frame.
    wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (p) drive_bit(pbit);
    drive_bit(sbit);

    exp_d   = d & m;
    ones    = $countones(exp_d);
    exp_par = s ? ~e : (e ? ones[0] : ~ones[0]);
    exp_pe  = p & (pbit != exp_par);
    exp_fe  = ~sbit;
    exp_bk  = (exp_d == 8'h00) && (!p || !pbit) && !sbit;

    chk({tag, "_done_cnt"}, done_cnt - dn0, 1);
    chk({tag, "_shifts"}, shift_cnt - sh0, nb + int'(p) + 1);
    chk({tag, "_errchk_cnt"}, ec_cnt - ec0, 1);
    chk({tag, "_done_lat"}, done_cyc - last_shift_cyc, 2);
    chk({tag, "_errchk_lat"}, done_cyc - ec_cyc, 1);
    chk({tag, "_data"}, rx_if.rx_data, exp_d);
    chk({tag, "_parity"}, rx_if.parity_err, exp_pe);
    chk({tag, "_framing"}, rx_if.framing_err, exp_fe);
    chk({tag, "_break"}, rx_if.break_det, exp_bk);
    chk({tag, "_overrun"}, rx_if.overrun_err, rbr);
    $display("frame %s: wls=%0d pen=%0b eps=%0b sp=%0b data=%02h -> rx_data=%02h pe=%0b fe=%0b bk=%0b ov=%0b",
             tag, w, p, e, s, d, rx_if.rx_data, rx_if.parity_err, rx_if.framing_err,
             rx_if.break_det, rx_if.overrun_err);

    set_line(1'b1);
    repeat (gap) @(negedge pclk);
  endtask

  initial begin
    int sh0, dn0, b0;
    logic [7:0] d;
    rx_if.rbr_full = 1'b0;
    rx_if.rsr_data = 8'h00;

    // Reset state
    repeat (5) @(negedge pclk);
    chk("rst_busy", rx_if.rx_busy, 0);
    chk("rst_shift", rx_if.receive_shift_en, 0);
    chk("rst_done", rx_if.rx_done, 0);
    chk("rst_errchk", rx_if.error_check, 0);
    chk("rst_data", rx_if.rx_data, 0);
    chk("rst_flags", {rx_if.parity_err, rx_if.framing_err, rx_if.break_det, rx_if.overrun_err}, 0);
    presetn = 1'b0;
    repeat (20) @(negedge pclk);

    run_frame("8n1_a5", 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 20);
    run_frame("7e1_41_bad", 2'b10, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 20);
    run_frame("7s1_41_ok", 2'b10, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 20);

    // Short low glitch on an idle line: false start only
    sh0 = shift_cnt; dn0 = done_cnt; b0 = busy_cnt;
    uart_rxd = 1'b0;
    repeat (16) @(negedge pclk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge pclk);
    chk("glitch_shifts", shift_cnt - sh0, 0);
    chk("glitch_done", done_cnt - dn0, 0);
    chk("glitch_busy_short", ((busy_cnt - b0) > 0) && ((busy_cnt - b0) < 40), 1);
    chk("glitch_idle", rx_if.rx_busy, 0);
    $display("glitch: busy for %0d pclk", busy_cnt - b0);

    // Break: line held low for two 5N1 frame times
    wls = 2'b00; pen = 1'b0;
    rx_if.rsr_data = 8'($urandom) & 8'hE0;
    sh0 = shift_cnt; dn0 = done_cnt;
    uart_rxd = 1'b0;
    repeat (2 * 7 * BIT_CLKS) @(negedge pclk);
    chk("break_done", done_cnt - dn0, 1);
    chk("break_shifts", shift_cnt - sh0, 6);
    chk("break_data", rx_if.rx_data, 0);
    chk("break_framing", rx_if.framing_err, 1);
    chk("break_det", rx_if.break_det, 1);
    chk("break_parity", rx_if.parity_err, 0);
    uart_rxd = 1'b1;
    repeat (200) @(negedge pclk);
    chk("break_no_rerun", done_cnt - dn0, 1);
    $display("break: rx_data=%02h fe=%0b bk=%0b", rx_if.rx_data, rx_if.framing_err, rx_if.break_det);

    // Back-to-back frames, RBR still full at the second capture
    run_frame("b2b_3c", 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 0);
    run_frame("b2b_c3", 2'b11, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 20);
    rx_if.rbr_full = 1'b0;

    // Reset during data bit 3
    wls = 2'b11; pen = 1'b0;
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    uart_rxd = d[3];
    repeat (30) @(negedge pclk);
    chk("prerst_busy", rx_if.rx_busy, 1);
    #2;
    presetn = 1'b1;
    uart_rxd = 1'b1;
    #1;
    chk("arst_busy", rx_if.rx_busy, 0);
    chk("arst_data", rx_if.rx_data, 0);
    chk("arst_overrun", rx_if.overrun_err, 0);
    chk("arst_done", rx_if.rx_done, 0);
    chk("arst_shift", rx_if.receive_shift_en, 0);
    sh0 = shift_cnt; dn0 = done_cnt;
    @(negedge pclk);
    presetn = 1'b0;
    repeat (300) @(negedge pclk);
    chk("arst_no_shift", shift_cnt - sh0, 0);
    chk("arst_no_done", done_cnt - dn0, 0);
    $display("reset mid-frame: aborted, busy=%0b", rx_if.rx_busy);

    // Loopback source, external line held low to prove it is ignored
    loop = 1'b1;
    repeat (4) @(negedge pclk);
    uart_rxd = 1'b0;
    run_frame("loop_5a", 2'b11, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 20);
    uart_rxd = 1'b1;
    repeat (4) @(negedge pclk);
    loop = 1'b0;
    repeat (10) @(negedge pclk);

    // Randomized frames
    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("rand%0d", k), 2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                1'($urandom), 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
